// File: rtl/multip_requant.sv
`default_nettype none
// ============================================================================
//  Module   : multip_requant
//  Purpose  : Round-half-up and saturate a complex twiddle product back to the
//             sample format, in two pipeline stages with valid/ready on both sides.
//  Revision : 1.0 - initial release
// ============================================================================
module multip_requant #(
  parameter int NBITS      = 10,
  parameter int NBITScoeff = 11,
  parameter int NBITS_out  = NBITS + NBITScoeff + 1,
  parameter int SHIFT      = NBITScoeff - 1,
  parameter int CNTW       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*NBITS_out-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*NBITS-1:0]       out_data,
  output logic                     out_sat,
  output logic [CNTW-1:0]          sat_count,
  input  logic                     sat_clr
);

  localparam int                 RW        = NBITS_out + 1 - SHIFT;
  localparam logic [NBITS_out:0] c_half    = (NBITS_out+1)'(1) << (SHIFT-1);
  localparam logic [NBITS-1:0]   c_pos_max = {1'b0, {(NBITS-1){1'b1}}};
  localparam logic [NBITS-1:0]   c_neg_max = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [CNTW-1:0]    c_cnt_max = '1;

  logic               r_s1_valid;
  logic [RW-1:0]      r_s1_re;
  logic [RW-1:0]      r_s1_im;
  logic               r_s2_valid;
  logic [2*NBITS-1:0] r_out_data;
  logic               r_out_sat;
  logic [CNTW-1:0]    r_sat_count;

  logic               w_s2_adv;
  logic               w_s1_adv;
  logic               w_out_xfer;
  logic [NBITS_out:0] w_re_sum;
  logic [NBITS_out:0] w_im_sum;
  logic [NBITS:0]     w_re_sat;
  logic [NBITS:0]     w_im_sat;

  // Returns {saturated, value}: the value fits when all bits above the
  // output sign bit agree with it.
  function automatic logic [NBITS:0] f_sat(input logic [RW-1:0] r);
    logic [RW-NBITS:0] top;
    top = r[RW-1:NBITS-1];
    if (top == '0 || top == '1) f_sat = {1'b0, r[NBITS-1:0]};
    else if (r[RW-1])           f_sat = {1'b1, c_neg_max};
    else                        f_sat = {1'b1, c_pos_max};
  endfunction

  assign w_s2_adv   = !r_s2_valid || out_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign w_out_xfer = r_s2_valid && out_ready;

  // Sign-extend by one bit so adding the half-LSB can never overflow.
  assign w_re_sum = {in_data[2*NBITS_out-1], in_data[2*NBITS_out-1:NBITS_out]} + c_half;
  assign w_im_sum = {in_data[NBITS_out-1], in_data[NBITS_out-1:0]} + c_half;

  assign w_re_sat = f_sat(r_s1_re);
  assign w_im_sat = f_sat(r_s1_im);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_re    <= '0;
      r_s1_im    <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_re <= w_re_sum[NBITS_out:SHIFT];
        r_s1_im <= w_im_sum[NBITS_out:SHIFT];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= {w_re_sat[NBITS-1:0], w_im_sat[NBITS-1:0]};
        r_out_sat  <= w_re_sat[NBITS] | w_im_sat[NBITS];
      end
    end
  end

  // Clear wins over a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || sat_clr) begin
      r_sat_count <= '0;
    end else if (w_out_xfer && r_out_sat && r_sat_count != c_cnt_max) begin
      r_sat_count <= r_sat_count + CNTW'(1);
    end
  end

  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign sat_count = r_sat_count;

endmodule
`default_nettype wire

// File: tb/tb_multip_requant.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_multip_requant
//  Purpose  : Scoreboard bench for multip_requant against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multip_requant;

  localparam int NBITS      = 10;
  localparam int NBITScoeff = 11;
  localparam int NBITS_out  = NBITS + NBITScoeff + 1;
  localparam int SHIFT      = NBITScoeff - 1;
  localparam int CNTW       = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [2*NBITS_out-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*NBITS-1:0]     out_data;
  logic                   out_sat;
  logic [CNTW-1:0]        sat_count;
  logic                   sat_clr;

  always #5 clk = ~clk;

  multip_requant #(
    .NBITS(NBITS), .NBITScoeff(NBITScoeff), .NBITS_out(NBITS_out),
    .SHIFT(SHIFT), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .sat_count(sat_count), .sat_clr(sat_clr)
  );

  typedef struct packed {
    logic [2*NBITS-1:0] data;
    logic               sat;
    logic [31:0]        cyc;
    logic               lat;
  } exp_t;

  exp_t q[$];
  int   n_cmp    = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   exp_cnt  = 0;
  bit   lat_mode = 0;
  bit   rand_on  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // floor((x + half) / 2^SHIFT), then clamp to the signed NBITS range
  function automatic int model(input int x, output bit s);
    int qv, r;
    qv = x + 2**(SHIFT-1);
    if (qv >= 0) r = qv / 2**SHIFT;
    else         r = -((-qv + 2**SHIFT - 1) / 2**SHIFT);
    s = 0;
    if (r > 2**(NBITS-1) - 1) begin r = 2**(NBITS-1) - 1; s = 1; end
    else if (r < -(2**(NBITS-1))) begin r = -(2**(NBITS-1)); s = 1; end
    return r;
  endfunction

  function automatic int rval();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 4194303)) - 2097152;
      1:       return int'($urandom_range(0, 1200000)) - 600000;
      default: return int'($urandom_range(0, 1048576)) - 524288;
    endcase
  endfunction

  task automatic send(input int re, input int im);
    exp_t        e;
    bit          s1, s2;
    logic [31:0] a, b;
    int          k;
    a = model(re, s1);
    b = model(im, s2);
    e.data = {a[NBITS-1:0], b[NBITS-1:0]};
    e.sat  = s1 | s2;
    e.lat  = lat_mode;
    e.cyc  = '0;
    a = re;
    b = im;
    in_data  = {a[NBITS_out-1:0], b[NBITS_out-1:0]};
    in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin k++; @(negedge clk); end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: in_ready stuck at 0 expected 1");
    end else begin
      e.cyc = cyc;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every output transfer and tracks sat_count.
  logic [2*NBITS-1:0] prev_data;
  logic               prev_sat;
  bit                 prev_stall = 0;
  exp_t               me;
  bit                 msat;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_cnt    = 0;
      prev_stall = 0;
    end else begin
      chk("sat_count", 32'(sat_count), exp_cnt);
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_hold", {11'd0, out_sat, out_data}, {11'd0, prev_sat, prev_data});
      end
      msat = 0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_output: got 0x%0h expected none", out_data);
        end else begin
          me = q.pop_front();
          chk("out_data", 32'(out_data), 32'(me.data));
          chk("out_sat", 32'(out_sat), 32'(me.sat));
          if (me.lat) chk("latency", cyc - me.cyc, 2);
          msat = me.sat;
        end
      end
      if (sat_clr) exp_cnt = 0;
      else if (msat && exp_cnt < 2**CNTW - 1) exp_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_sat   = out_sat;
    end
  end

  initial begin
    int k;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sat_clr = 1'b0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_sat", 32'(out_sat), 0);
    chk("rst_sat_count", 32'(sat_count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Rounding, streamed back to back
    lat_mode = 1;
    send(102400, -102400);
    send(512, -512);
    send(-513, 1535);
    lat_mode = 0;
    idle(4);

    // Saturation
    send(600000, -600000);
    send(600000, 0);
    idle(4);
    chk("sat_count_two", 32'(sat_count), 2);

    // Backpressure: 4-cycle stall while streaming 5 words
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(int'($urandom_range(0, 200000)) - 100000, rval());
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_accepted", q.size(), 2);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(4);

    // Counter saturation at all-ones
    for (int i = 0; i < 20; i++) send(700000, -700000);
    idle(4);
    chk("cnt_hold_max", 32'(sat_count), 2**CNTW - 1);

    // sat_clr coincident with a saturating transfer
    out_ready = 1'b0;
    send(600000, 600000);
    k = 0;
    while (!out_valid && k < 10) begin k++; @(posedge clk); #1; end
    chk("clr_setup_valid", 32'(out_valid), 1);
    sat_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    @(negedge clk);
    chk("clr_priority", 32'(sat_count), 0);
    @(posedge clk); #1;

    // Mid-stream reset with two words in flight
    send(-600000, 5); send(-600000, 5); send(-600000, 5);
    idle(4);
    out_ready = 1'b0;
    send(1000, 2000);
    send(3000, 4000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_sat_count", 32'(sat_count), 0);
    chk("mrst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    lat_mode  = 1;
    send(2048, -2048);
    lat_mode  = 0;
    idle(4);

    // Randomized traffic with random backpressure and occasional clears
    rand_on = 1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          send(rval(), rval());
        end
        rand_on = 0;
      end
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
          sat_clr   = ($urandom_range(0, 31) == 0);
        end
      end
    join
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    k = 0;
    while (q.size() != 0 && k < 50) begin k++; @(posedge clk); #1; end
    chk("drain_empty", q.size(), 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
